// File: rtl/pipelined_control_unit_if.sv
// ID-stage instruction, hazard flush and the staged control bundle exchanged
// between the control unit (slave) and the datapath/hazard unit (master).
interface pipelined_control_unit_if;
  logic [31:0] InstrD;
  logic        FlushE;
  logic        BranchD;
  logic        BranchNeD;
  logic        JumpD;
  logic        IllegalD;
  logic        StallFD;
  logic        RegWriteE;
  logic        MemtoRegE;
  logic        MemWriteE;
  logic        ALUSrcE;
  logic        RegDstE;
  logic        ZeroExtE;
  logic [2:0]  ALUControlE;
  logic        RegWriteM;
  logic        MemtoRegM;
  logic        MemWriteM;
  logic        RegWriteW;
  logic        MemtoRegW;

  modport master (
    output InstrD, FlushE,
    input  BranchD, BranchNeD, JumpD, IllegalD, StallFD,
    input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ZeroExtE, ALUControlE,
    input  RegWriteM, MemtoRegM, MemWriteM,
    input  RegWriteW, MemtoRegW
  );

  modport slave (
    input  InstrD, FlushE,
    output BranchD, BranchNeD, JumpD, IllegalD, StallFD,
    output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ZeroExtE, ALUControlE,
    output RegWriteM, MemtoRegM, MemWriteM,
    output RegWriteW, MemtoRegW
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// MIPS 5-stage control unit: ID decode plus ID/EX, EX/MEM and MEM/WB control
// registers, with bubble insertion and a multi-cycle MUL hold in EX.
module pipelined_control_unit #(
  parameter int MUL_LATENCY = 3,
  parameter bit EXT_EN      = 1'b1,
  parameter int CNT_W       = 4
) (
  input logic                      CLK,
  input logic                      RST,
  pipelined_control_unit_if.slave  bus
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic       zero_ext;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  localparam ctrl_t NOP_CTRL = 9'b000000_010;
  localparam bit MUL_MULTI = (MUL_LATENCY > 1);
  localparam logic [CNT_W-1:0] MUL_RELOAD = CNT_W'(MUL_LATENCY - 1);

  ctrl_t            dec;
  ctrl_t            id_ex;
  logic             branch;
  logic             branch_ne;
  logic             jump;
  logic             illegal;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [CNT_W-1:0] cnt;
  logic             stall;
  logic             mul_capture;
  logic             m_reg_write;
  logic             m_mem_to_reg;
  logic             m_mem_write;
  logic             w_reg_write;
  logic             w_mem_to_reg;

  assign opcode = bus.InstrD[31:26];
  assign funct  = bus.InstrD[5:0];

  always_comb begin
    dec       = NOP_CTRL;
    branch    = 1'b0;
    branch_ne = 1'b0;
    jump      = 1'b0;
    illegal   = 1'b0;
    if (bus.InstrD != '0) begin
      case (opcode)
        6'b000000: begin
          dec.reg_write = 1'b1;
          dec.reg_dst   = 1'b1;
          case (funct)
            6'b100100: dec.alu_ctrl = 3'b000;
            6'b100101: dec.alu_ctrl = 3'b001;
            6'b100000: dec.alu_ctrl = 3'b010;
            6'b100010: dec.alu_ctrl = 3'b100;
            6'b101010: dec.alu_ctrl = 3'b110;
            6'b011100: dec.alu_ctrl = 3'b101;
            default: begin
              dec     = NOP_CTRL;
              illegal = 1'b1;
            end
          endcase
        end
        6'b100011: begin
          dec.reg_write  = 1'b1;
          dec.alu_src    = 1'b1;
          dec.mem_to_reg = 1'b1;
        end
        6'b101011: begin
          dec.mem_write = 1'b1;
          dec.alu_src   = 1'b1;
        end
        6'b001000: begin
          dec.reg_write = 1'b1;
          dec.alu_src   = 1'b1;
        end
        6'b000100: begin
          branch       = 1'b1;
          dec.alu_ctrl = 3'b100;
        end
        6'b000010: jump = 1'b1;
        // Extended opcodes decode only when EXT_EN is set; otherwise illegal.
        6'b001100: begin
          if (EXT_EN) begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.zero_ext  = 1'b1;
            dec.alu_ctrl  = 3'b000;
          end else illegal = 1'b1;
        end
        6'b001101: begin
          if (EXT_EN) begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.zero_ext  = 1'b1;
            dec.alu_ctrl  = 3'b001;
          end else illegal = 1'b1;
        end
        6'b001010: begin
          if (EXT_EN) begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.alu_ctrl  = 3'b110;
          end else illegal = 1'b1;
        end
        6'b000101: begin
          if (EXT_EN) begin
            branch_ne    = 1'b1;
            dec.alu_ctrl = 3'b100;
          end else illegal = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  assign stall       = (cnt != '0);
  assign mul_capture = MUL_MULTI && !stall && !bus.FlushE &&
                       dec.reg_write && (dec.alu_ctrl == 3'b101);

  // While the counter runs, ID/EX holds the MUL and FlushE has no effect.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      id_ex <= NOP_CTRL;
      cnt   <= '0;
    end else if (stall) begin
      cnt <= cnt - CNT_W'(1);
    end else if (bus.FlushE) begin
      id_ex <= NOP_CTRL;
    end else begin
      id_ex <= dec;
      if (mul_capture) cnt <= MUL_RELOAD;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_reg_write  <= 1'b0;
      m_mem_to_reg <= 1'b0;
      m_mem_write  <= 1'b0;
      w_reg_write  <= 1'b0;
      w_mem_to_reg <= 1'b0;
    end else begin
      m_reg_write  <= stall ? 1'b0 : id_ex.reg_write;
      m_mem_to_reg <= stall ? 1'b0 : id_ex.mem_to_reg;
      m_mem_write  <= stall ? 1'b0 : id_ex.mem_write;
      w_reg_write  <= m_reg_write;
      w_mem_to_reg <= m_mem_to_reg;
    end
  end

  assign bus.BranchD     = branch;
  assign bus.BranchNeD   = branch_ne;
  assign bus.JumpD       = jump;
  assign bus.IllegalD    = illegal;
  assign bus.StallFD     = stall;
  assign bus.RegWriteE   = id_ex.reg_write;
  assign bus.MemtoRegE   = id_ex.mem_to_reg;
  assign bus.MemWriteE   = id_ex.mem_write;
  assign bus.ALUSrcE     = id_ex.alu_src;
  assign bus.RegDstE     = id_ex.reg_dst;
  assign bus.ZeroExtE    = id_ex.zero_ext;
  assign bus.ALUControlE = id_ex.alu_ctrl;
  assign bus.RegWriteM   = m_reg_write;
  assign bus.MemtoRegM   = m_mem_to_reg;
  assign bus.MemWriteM   = m_mem_write;
  assign bus.RegWriteW   = w_reg_write;
  assign bus.MemtoRegW   = w_mem_to_reg;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: decode/latency vector table plus
// MUL hold, flush, back-to-back MUL, async reset and EXT_EN=0 sequences.
module tb_pipelined_control_unit;

  typedef struct {
    logic [31:0] instr;
    logic        flush;
    logic [3:0]  exp_d;
    logic [8:0]  exp_e;
  } vec_t;

  localparam logic [8:0]  E_NOP   = 9'b000000_010;
  localparam logic [8:0]  E_MUL   = 9'b100010_101;
  localparam logic [8:0]  E_ADD   = 9'b100010_010;
  localparam logic [8:0]  E_LW    = 9'b110100_010;
  localparam logic [14:0] ALL_NOP = {E_NOP, 6'b0};
  localparam logic [31:0] I_MUL   = 32'h0022181C;
  localparam logic [31:0] I_ADD   = 32'h00221820;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[18];

  always #5 clk = ~clk;

  pipelined_control_unit_if bus ();
  pipelined_control_unit_if bus_ne ();

  pipelined_control_unit #(.MUL_LATENCY(3), .EXT_EN(1'b1), .CNT_W(4)) dut (
    .CLK(clk), .RST(rst_n), .bus(bus)
  );

  pipelined_control_unit #(.MUL_LATENCY(3), .EXT_EN(1'b0), .CNT_W(4)) dut_ne (
    .CLK(clk), .RST(rst_n), .bus(bus_ne)
  );

  wire [3:0]  d_act    = {bus.BranchD, bus.BranchNeD, bus.JumpD, bus.IllegalD};
  wire [8:0]  e_act    = {bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.ALUSrcE,
                          bus.RegDstE, bus.ZeroExtE, bus.ALUControlE};
  wire [2:0]  m_act    = {bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM};
  wire [1:0]  w_act    = {bus.RegWriteW, bus.MemtoRegW};
  wire [14:0] all_act  = {e_act, m_act, w_act, bus.StallFD};
  wire [3:0]  d_ne     = {bus_ne.BranchD, bus_ne.BranchNeD, bus_ne.JumpD, bus_ne.IllegalD};
  wire [8:0]  e_ne     = {bus_ne.RegWriteE, bus_ne.MemtoRegE, bus_ne.MemWriteE, bus_ne.ALUSrcE,
                          bus_ne.RegDstE, bus_ne.ZeroExtE, bus_ne.ALUControlE};
  wire [14:0] all_ne   = {e_ne, bus_ne.RegWriteM, bus_ne.MemtoRegM, bus_ne.MemWriteM,
                          bus_ne.RegWriteW, bus_ne.MemtoRegW, bus_ne.StallFD};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic flush);
    @(negedge clk);
    bus.InstrD = instr;
    bus.FlushE = flush;
  endtask

  task automatic applyStimulusNe(input logic [31:0] instr);
    @(negedge clk);
    bus_ne.InstrD = instr;
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] e1;
    logic [8:0] e2;

    // {instr, flush, {BranchD,BranchNeD,JumpD,IllegalD}, E bundle}
    vecs[0]  = '{32'h8C220004, 1'b0, 4'b0000, 9'b110100_010};
    vecs[1]  = '{32'hAC220004, 1'b0, 4'b0000, 9'b001100_010};
    vecs[2]  = '{32'h20220005, 1'b0, 4'b0000, 9'b100100_010};
    vecs[3]  = '{32'h34220005, 1'b0, 4'b0000, 9'b100101_001};
    vecs[4]  = '{32'h30220001, 1'b0, 4'b0000, 9'b100101_000};
    vecs[5]  = '{32'h28220003, 1'b0, 4'b0000, 9'b100100_110};
    vecs[6]  = '{32'h10220003, 1'b0, 4'b1000, 9'b000000_100};
    vecs[7]  = '{32'h14220003, 1'b0, 4'b0100, 9'b000000_100};
    vecs[8]  = '{32'h08000010, 1'b0, 4'b0010, 9'b000000_010};
    vecs[9]  = '{32'h00221820, 1'b0, 4'b0000, 9'b100010_010};
    vecs[10] = '{32'h00221822, 1'b0, 4'b0000, 9'b100010_100};
    vecs[11] = '{32'h00221824, 1'b0, 4'b0000, 9'b100010_000};
    vecs[12] = '{32'h00221825, 1'b0, 4'b0000, 9'b100010_001};
    vecs[13] = '{32'h0022182A, 1'b0, 4'b0000, 9'b100010_110};
    vecs[14] = '{32'h00221801, 1'b0, 4'b0001, 9'b000000_010};
    vecs[15] = '{32'hFC000000, 1'b0, 4'b0001, 9'b000000_010};
    vecs[16] = '{32'h00221820, 1'b1, 4'b0000, 9'b000000_010};
    vecs[17] = '{32'h00000000, 1'b0, 4'b0000, 9'b000000_010};

    // Reset with arbitrary instructions present in ID
    bus.InstrD    = $urandom;
    bus.FlushE    = 1'b0;
    bus_ne.InstrD = $urandom;
    bus_ne.FlushE = 1'b0;
    repeat (2) waitCycle();
    checkOutput("reset_state", 32'(all_act), 32'(ALL_NOP));
    checkOutput("reset_state_ne", 32'(all_ne), 32'(ALL_NOP));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_release_hold", 32'(all_act), 32'(ALL_NOP));
    #1;
    bus.InstrD    = '0;
    bus_ne.InstrD = '0;
    repeat (2) waitCycle();
    checkOutput("idle_nop", 32'(all_act), 32'(ALL_NOP));

    // Decode table with E/M/W latency tracking
    e1 = E_NOP;
    e2 = E_NOP;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].instr, vecs[i].flush);
      #1;
      checkOutput($sformatf("vec%0d_decode", i), 32'(d_act), 32'(vecs[i].exp_d));
      waitCycle();
      checkOutput($sformatf("vec%0d_e", i), 32'(e_act), 32'(vecs[i].exp_e));
      checkOutput($sformatf("vec%0d_m", i), 32'(m_act), 32'(e1[8:6]));
      checkOutput($sformatf("vec%0d_w", i), 32'(w_act), 32'(e2[8:7]));
      checkOutput($sformatf("vec%0d_stall", i), 32'(bus.StallFD), 32'd0);
      e2 = e1;
      e1 = vecs[i].exp_e;
    end
    applyStimulus('0, 1'b0);
    repeat (3) waitCycle();

    // MUL holds EX for 3 cycles, flush during hold is ignored
    applyStimulus(I_MUL, 1'b0);
    #1;
    checkOutput("mul_id_nostall", 32'(bus.StallFD), 32'd0);
    waitCycle();
    checkOutput("mul_c1_e", 32'(e_act), 32'(E_MUL));
    checkOutput("mul_c1_stall", 32'(bus.StallFD), 32'd1);
    applyStimulus(I_ADD, 1'b1);
    waitCycle();
    checkOutput("mul_c2_flush_ignored", 32'(e_act), 32'(E_MUL));
    checkOutput("mul_c2_stall", 32'(bus.StallFD), 32'd1);
    checkOutput("mul_c2_m", 32'(m_act), 32'd0);
    applyStimulus(I_ADD, 1'b0);
    waitCycle();
    checkOutput("mul_c3_e", 32'(e_act), 32'(E_MUL));
    checkOutput("mul_c3_stall", 32'(bus.StallFD), 32'd0);
    checkOutput("mul_c3_m", 32'(m_act), 32'd0);
    waitCycle();
    checkOutput("mul_c4_add_e", 32'(e_act), 32'(E_ADD));
    checkOutput("mul_c4_m", 32'(m_act), 32'b100);
    applyStimulus('0, 1'b0);
    waitCycle();
    checkOutput("mul_c5_w", 32'(w_act), 32'b10);
    repeat (2) waitCycle();

    // FlushE wins over a MUL decode; no counter load
    applyStimulus(I_MUL, 1'b1);
    waitCycle();
    checkOutput("flush_mul_e", 32'(e_act), 32'(E_NOP));
    checkOutput("flush_mul_stall", 32'(bus.StallFD), 32'd0);
    applyStimulus('0, 1'b0);
    waitCycle();
    checkOutput("flush_mul_after", 32'(bus.StallFD), 32'd0);

    // Back-to-back MULs: second captured when the counter reaches zero
    applyStimulus(I_MUL, 1'b0);
    waitCycle();
    checkOutput("b2b_c1_stall", 32'(bus.StallFD), 32'd1);
    waitCycle();
    checkOutput("b2b_c2_stall", 32'(bus.StallFD), 32'd1);
    waitCycle();
    checkOutput("b2b_c3_stall", 32'(bus.StallFD), 32'd0);
    waitCycle();
    checkOutput("b2b_c4_e", 32'(e_act), 32'(E_MUL));
    checkOutput("b2b_c4_reload", 32'(bus.StallFD), 32'd1);
    checkOutput("b2b_c4_m", 32'(m_act), 32'b100);
    applyStimulus('0, 1'b0);
    waitCycle();
    checkOutput("b2b_c5_stall", 32'(bus.StallFD), 32'd1);
    waitCycle();
    checkOutput("b2b_c6_m", 32'(m_act), 32'd0);
    checkOutput("b2b_c6_stall", 32'(bus.StallFD), 32'd0);
    waitCycle();
    checkOutput("b2b_c7_e", 32'(e_act), 32'(E_NOP));
    checkOutput("b2b_c7_m", 32'(m_act), 32'b100);
    repeat (2) waitCycle();

    // Asynchronous reset while the counter is 1
    applyStimulus(I_MUL, 1'b0);
    waitCycle();
    applyStimulus('0, 1'b0);
    waitCycle();
    checkOutput("areset_pre_stall", 32'(bus.StallFD), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_stall_drop", 32'(bus.StallFD), 32'd0);
    checkOutput("areset_all_nop", 32'(all_act), 32'(ALL_NOP));
    @(negedge clk);
    rst_n = 1'b1;
    waitCycle();
    checkOutput("areset_after", 32'(all_act), 32'(ALL_NOP));

    // EXT_EN=0 instance: extended opcodes are illegal
    applyStimulusNe(32'h30220001);
    #1;
    checkOutput("ne_andi_illegal", 32'(d_ne), 32'b0001);
    waitCycle();
    checkOutput("ne_andi_e", 32'(e_ne), 32'(E_NOP));
    applyStimulusNe(32'h14220003);
    #1;
    checkOutput("ne_bne_illegal", 32'(d_ne), 32'b0001);
    applyStimulusNe(32'h00221801);
    #1;
    checkOutput("ne_funct_illegal", 32'(d_ne), 32'b0001);
    applyStimulusNe(32'h8C220004);
    #1;
    checkOutput("ne_lw_decode", 32'(d_ne), 32'b0000);
    waitCycle();
    checkOutput("ne_lw_e", 32'(e_ne), 32'(E_LW));
    applyStimulusNe('0);
    #1;
    checkOutput("ne_zero_legal", 32'(d_ne), 32'b0000);
    waitCycle();
    checkOutput("ne_zero_e", 32'(e_ne), 32'(E_NOP));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
